// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin mux scheduler.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        OUT  = 2'd2
    } arb_state_t;

    localparam int         N_REQ    = 11;
    localparam logic [3:0] SS_IDLE  = 4'hF;
    localparam logic [3:0] LAST_RST = 4'd10;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or after (last+1) mod 11.
module rr_pick
    import arb_pkg::*;
(
    input  logic [10:0] req,
    input  logic [3:0]  last,
    output logic        any,
    output logic [3:0]  idx
);

    logic [4:0] start;
    logic [4:0] pos;

    always_comb begin
        any   = 1'b0;
        idx   = 4'd0;
        pos   = 5'd0;
        // last is only ever 0..10; anything else falls back to index 0 first
        start = (last >= 4'd10) ? 5'd0 : ({1'b0, last} + 5'd1);
        for (int k = 0; k < N_REQ; k++) begin
            pos = start + 5'(k);
            if (pos >= 5'd11)
                pos = pos - 5'd11;
            if (!any && req[pos[3:0]]) begin
                any = 1'b1;
                idx = pos[3:0];
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin scheduler owning the select of the 11-input result mux; the
// selected word is registered and offered on a valid/ready port.
module mux_rr_arbiter
    import arb_pkg::*;
#(
    parameter int n     = 4,
    parameter int N_REQ = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [n-1:0]     mux_out,
    input  logic             out_ready,
    output logic [3:0]       ss,
    output logic [N_REQ-1:0] gnt,
    output logic [n-1:0]     out_data,
    output logic             out_valid,
    output logic             busy
);

    arb_state_t state, state_nxt;
    logic [3:0] last;
    logic [3:0] win;
    logic       any;
    logic [3:0] idx;
    logic       arb_fire;

    rr_pick u_pick (
        .req  (req),
        .last (last),
        .any  (any),
        .idx  (idx)
    );

    // A new arbitration happens from IDLE, or straight out of OUT on handshake.
    assign arb_fire = any && ((state == IDLE) || ((state == OUT) && out_ready));

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = SEL;
            SEL:     state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = any ? SEL : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    // Select, grant pulse and captured word; gnt is high only for the SEL cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss       <= SS_IDLE;
            gnt      <= '0;
            out_data <= '0;
            last     <= LAST_RST;
            win      <= 4'd0;
        end else begin
            gnt <= '0;
            if (arb_fire) begin
                win      <= idx;
                ss       <= idx;
                gnt[idx] <= 1'b1;
            end else if (state == SEL) begin
                out_data <= mux_out;
                last     <= win;
                ss       <= SS_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter with a behavioural 11-input mux.
module tb_mux_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] req;
    logic [3:0]  mux_out;
    logic        out_ready;
    logic [3:0]  ss;
    logic [10:0] gnt;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        busy;

    logic [3:0]  mux_in [0:10];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [10:0] req;
        logic        rdy;
        logic [3:0]  ss;
        logic [10:0] gnt;
        logic        vld;
        logic        busy;
        logic [3:0]  data;
    } vec_t;

    vec_t tbl [9];

    int          exp_q [$];
    logic [3:0]  dat_q [$];

    always #5 clk = ~clk;

    always_comb begin
        mux_out = 4'h0;
        if (ss <= 4'd10)
            mux_out = mux_in[ss];
    end

    mux_rr_arbiter #(.n(4), .N_REQ(11)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mux_out   (mux_out),
        .out_ready (out_ready),
        .ss        (ss),
        .gnt       (gnt),
        .out_data  (out_data),
        .out_valid (out_valid),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference round robin: first set bit after 'lst', ascending with wrap.
    function automatic int rr_ref(input logic [10:0] r, input int lst);
        for (int k = 1; k <= 11; k++) begin
            if (r[(lst + k) % 11])
                return (lst + k) % 11;
        end
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string nm, input logic [3:0] d);
        chk({nm, "_ss"}, ss, 4'hF);
        chk({nm, "_gnt"}, gnt, 11'h000);
        chk({nm, "_vld"}, out_valid, 1'b0);
        chk({nm, "_busy"}, busy, 1'b0);
        chk({nm, "_data"}, out_data, d);
    endtask

    initial begin
        int ml, w, e, seen, last_cyc;
        logic [3:0] d;

        for (int i = 0; i < 11; i++)
            mux_in[i] = 4'(i + 5);
        mux_in[3] = 4'h9;

        //               req      rdy   ss     gnt      vld   busy  data
        tbl[0] = '{11'h000, 1'b0, 4'hF, 11'h000, 1'b0, 1'b0, 4'h0};
        tbl[1] = '{11'h401, 1'b0, 4'h0, 11'h001, 1'b0, 1'b1, 4'h0};
        tbl[2] = '{11'h401, 1'b1, 4'hF, 11'h000, 1'b1, 1'b1, 4'h5};
        tbl[3] = '{11'h401, 1'b1, 4'hA, 11'h400, 1'b0, 1'b1, 4'h5};
        tbl[4] = '{11'h000, 1'b0, 4'hF, 11'h000, 1'b1, 1'b1, 4'hF};
        tbl[5] = '{11'h008, 1'b1, 4'h3, 11'h008, 1'b0, 1'b1, 4'hF};
        tbl[6] = '{11'h000, 1'b0, 4'hF, 11'h000, 1'b1, 1'b1, 4'h9};
        tbl[7] = '{11'h000, 1'b1, 4'hF, 11'h000, 1'b0, 1'b0, 4'h9};
        tbl[8] = '{11'h000, 1'b0, 4'hF, 11'h000, 1'b0, 1'b0, 4'h9};

        // Reset then idle
        do_reset();
        chk_idle("rst", 4'h0);
        repeat (4) begin
            step();
            chk_idle("idle_hold", 4'h0);
        end

        // Table: skip pattern 0 -> 10, then single request on d, then idle
        do_reset();
        for (int r = 0; r < 9; r++) begin
            req       = tbl[r].req;
            out_ready = tbl[r].rdy;
            step();
            chk($sformatf("tbl%0d_ss", r), ss, tbl[r].ss);
            chk($sformatf("tbl%0d_gnt", r), gnt, tbl[r].gnt);
            chk($sformatf("tbl%0d_vld", r), out_valid, tbl[r].vld);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].busy);
            chk($sformatf("tbl%0d_data", r), out_data, tbl[r].data);
        end

        // Round robin with wrap, scoreboarded
        do_reset();
        req       = 11'h7FF;
        out_ready = 1'b1;
        ml = 10;
        for (int i = 0; i < 12; i++) begin
            w = rr_ref(req, ml);
            exp_q.push_back(w);
            ml = w;
        end
        seen     = 0;
        last_cyc = -1;
        for (int c = 0; c < 40 && (seen < 12 || busy); c++) begin
            step();
            chk("wrap_ss_range", (ss >= 4'd11 && ss <= 4'd14), 1'b0);
            chk("wrap_onehot", ($countones(gnt) > 1), 1'b0);
            if (out_valid) begin
                if (dat_q.size() == 0) begin
                    chk("wrap_unexpected_valid", out_valid, 1'b0);
                end else begin
                    d = dat_q.pop_front();
                    chk("wrap_data", out_data, d);
                end
            end
            if (gnt != 11'h000) begin
                if (exp_q.size() == 0) begin
                    chk("wrap_extra_gnt", gnt, 11'h000);
                end else begin
                    e = exp_q.pop_front();
                    chk("wrap_gnt", gnt, 32'(11'(1) << e));
                    chk("wrap_ss", ss, e);
                    if (last_cyc >= 0)
                        chk("wrap_spacing", c - last_cyc, 2);
                    last_cyc = c;
                    dat_q.push_back(mux_in[e]);
                end
                seen++;
                if (seen == 12)
                    req = 11'h000;
            end
        end
        chk("wrap_all_grants", exp_q.size(), 0);
        chk("wrap_all_data", dat_q.size(), 0);
        chk("wrap_back_idle", busy, 1'b0);

        // Back-pressure on requester 1
        do_reset();
        req = 11'h002;
        step();
        chk("bp_sel_gnt", gnt, 11'h002);
        chk("bp_sel_ss", ss, 4'h1);
        step();
        chk("bp_out_data", out_data, mux_in[1]);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_hold_data", out_data, mux_in[1]);
            chk("bp_hold_vld", out_valid, 1'b1);
            chk("bp_hold_gnt", gnt, 11'h000);
            chk("bp_hold_ss", ss, 4'hF);
        end
        out_ready = 1'b1;
        step();
        chk("bp_release_gnt", gnt, 11'h002);
        chk("bp_release_ss", ss, 4'h1);
        chk("bp_release_vld", out_valid, 1'b0);

        // Reset in the middle of SEL
        do_reset();
        req = 11'h010;
        step();
        chk("midrst_sel_gnt", gnt, 11'h010);
        rst = 1'b1;
        req = 11'h000;
        step();
        chk_idle("midrst", 4'h0);
        rst = 1'b0;
        req = 11'h7FF;
        exp_q.push_back(rr_ref(req, 10));
        step();
        e = exp_q.pop_front();
        chk("midrst_first_gnt", gnt, 32'(11'(1) << e));
        chk("midrst_first_ss", ss, e);
        req = 11'h000;
        step();
        chk("midrst_out_data", out_data, mux_in[e]);
        chk("midrst_out_gnt", gnt, 11'h000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
